ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-keyboard PS/2 transmitter for the PC keyboard interface: sends one command byte
//  (e.g. 0xFF reset, 0xED set LEDs) to the keyboard over the shared open-drain clock/data pair.
//  Runs in the pclk domain and samples the keyboard clock through a synchronizer.
//  Checks for the device ACK, and reports done or error.
//  busy tells the keyboard receive path to ignore line activity while a transmit is in progress.
// PARAMETERS
//  INHIBIT_CYCLES  477    pclk cycles clock is held low before start (>=100us at 4.77MHz)
//  TIMEOUT_CYCLES  71550  max pclk cycles between keyboard clock falling edges (15ms) before abort
//  SYNC_STAGES     2      flops in the kbd_clk_in/kbd_data_in synchronizers (>=2)
// PORTS
//  pclk                input   1  system clock
//  reset_n             input   1  asynchronous reset, active-low
//  tx_data             input   8  command byte, sampled when tx_valid & tx_ready
//  tx_valid            input   1  request to send tx_data
//  tx_ready            output  1  high in IDLE; accepts a byte this cycle if tx_valid
//  tx_done             output  1  1-cycle pulse: byte sent and ACK (data=0) received
//  tx_error            output  1  1-cycle pulse: timeout or missing ACK
//  busy                output  1  high in every state except IDLE
//  kbd_clk_in          input   1  keyboard clock line as read (asynchronous)
//  kbd_data_in         input   1  keyboard data line as read (asynchronous)
//  kbd_clk_drive_low   output  1  1 = pull keyboard clock low; 0 = release (open-drain)
//  kbd_data_drive_low  output  1  1 = pull keyboard data low; 0 = release (open-drain)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, tx_ready=1, busy=0, tx_done=tx_error=0.
//    Both drive_low outputs are 0, so the lines are released immediately, including mid-transfer.
//  - Falling edge = synchronized clock previous=1, current=0; detected 1 cycle after the sync chain.
//  - Frame, LSB first: start(0), d0..d7, parity (odd: 1 + number of 1s in byte is odd), stop(1).
//  - IDLE: on tx_valid, latch tx_data, compute parity, set clk_drive_low=1, load the counter, -> INHIBIT.
//  - INHIBIT: clock held low for INHIBIT_CYCLES, then data_drive_low=1, -> START.
//  - START: one cycle with both lines low; then release the clock, clear bitcnt, -> SEND.
//  - SEND: on each falling edge, drive the next bit (data_drive_low = ~bit).
//    Edges 1-8 drive d0..d7, edge 9 drives parity, and edge 10 releases data (stop bit).
//    After edge 10, -> ACK.
//  - ACK: on the next falling edge, sample data. If 0, -> WAIT_IDLE. If 1, tx_error pulse and -> IDLE.
//  - WAIT_IDLE: when the synchronized clock and data are both 1, tx_done pulse and -> IDLE.
//  - Timeout: the counter reloads on every falling edge in SEND, ACK and WAIT_IDLE.
//    If it reaches TIMEOUT_CYCLES: release both lines, tx_error pulse, -> IDLE.
//  - tx_valid outside IDLE is ignored; no queuing. tx_done and tx_error are never high together.
//  - tx_ready rises in the same cycle as the done/error pulse. A new request is accepted the next cycle.
//  - kbd_clk_drive_low is high only in INHIBIT and START.
//  - The counter is sized to max(INHIBIT_CYCLES, TIMEOUT_CYCLES) and never wraps:
//    it saturates at the terminal count.
//  - Undefined state encodings -> IDLE with lines released.
// TESTING
//  1 tx_data=0xED, keyboard model clocks at 12.5kHz and ACKs.
//    -> line bits 0,1,0,1,1,0,1,1,1,1(par),1(stop); ACK; exactly one tx_done; busy 1->0.
//  2 tx_data=0x01, model ACKs -> parity bit 0.
//    tx_data=0x00 -> parity 1. Both give tx_done.
//  3 Model never clocks after start.
//    -> clock held low for exactly 477 cycles; after 71550 further cycles, tx_error pulse and both lines released.
//  4 Model leaves data=1 at edge 11 -> tx_error pulse, no tx_done, back to IDLE with tx_ready=1.
//  5 reset_n low during bit 4 -> both drive_low outputs 0 asynchronously.
//    After release, a 0xFF send completes normally.
//  6 tx_valid held through a send of 0xF4.
//    -> second byte accepted only in the cycle after tx_done; no tx_valid is taken while busy.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-keyboard PS/2 transmitter. Sends one command byte over the open-drain clock/data
// pair, checks the keyboard ACK and reports done or error. Runs entirely in the pclk domain;
// the keyboard lines are brought in through synchronizers.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 477,
  parameter int unsigned TIMEOUT_CYCLES = 71550,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       kbd_clk_in,
  input  logic       kbd_data_in,
  output logic       kbd_clk_drive_low,
  output logic       kbd_data_drive_low
);

  // One counter serves both the inhibit delay and the edge-to-edge timeout.
  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntTop      = CntW'(CntMax);
  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StInhibit  = 3'd1,
    StStart    = 3'd2,
    StSend     = 3'd3,
    StAck      = 3'd4,
    StWaitIdle = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  logic [7:0]      byte_q, byte_d;
  logic            parity_q, parity_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clk_drive_q, clk_drive_d;
  logic            data_drive_q, data_drive_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            clk_s;
  logic            data_s;
  logic            clk_fall;
  logic [CntW-1:0] cnt_inc;

  // Synchronizer shift and edge-detect history for the keyboard lines.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], kbd_clk_in};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], kbd_data_in};
    clk_prev_d  = clk_s;
  end

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign clk_fall = clk_prev_q & ~clk_s;

  // Synchronizer flops reset to the idle (released, pulled-up) line level.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  // Saturating increment: the counter parks at its terminal value instead of wrapping.
  assign cnt_inc = (cnt_q == CntTop) ? cnt_q : cnt_q + CntOne;

  // Next-state logic for the transmit sequence.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    parity_d     = parity_q;
    bitcnt_d     = bitcnt_q;
    cnt_d        = cnt_q;
    clk_drive_d  = clk_drive_q;
    data_drive_d = data_drive_q;
    done_d       = 1'b0;
    error_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_drive_d  = 1'b0;
        data_drive_d = 1'b0;
        if (tx_valid) begin
          byte_d      = tx_data;
          parity_d    = ~^tx_data;  // odd parity over data + parity bit
          clk_drive_d = 1'b1;
          cnt_d       = '0;
          state_d     = StInhibit;
        end
      end

      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          data_drive_d = 1'b1;
          state_d      = StStart;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StStart: begin
        // Data stays low as the start bit; releasing the clock hands timing to the keyboard.
        clk_drive_d = 1'b0;
        bitcnt_d    = '0;
        cnt_d       = '0;
        state_d     = StSend;
      end

      StSend: begin
        if (clk_fall) begin
          cnt_d    = '0;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q < 4'd8) begin
            data_drive_d = ~byte_q[bitcnt_q[2:0]];
          end else if (bitcnt_q == 4'd8) begin
            data_drive_d = ~parity_q;
          end else begin
            data_drive_d = 1'b0;  // stop bit: line floats high
            state_d      = StAck;
          end
        end else if (cnt_q == TimeoutLast) begin
          clk_drive_d  = 1'b0;
          data_drive_d = 1'b0;
          error_d      = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StAck: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (!data_s) begin
            state_d = StWaitIdle;
          end else begin
            data_drive_d = 1'b0;
            error_d      = 1'b1;
            state_d      = StIdle;
          end
        end else if (cnt_q == TimeoutLast) begin
          clk_drive_d  = 1'b0;
          data_drive_d = 1'b0;
          error_d      = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StWaitIdle: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (cnt_q == TimeoutLast) begin
          clk_drive_d  = 1'b0;
          data_drive_d = 1'b0;
          error_d      = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        clk_drive_d  = 1'b0;
        data_drive_d = 1'b0;
        state_d      = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset releases both lines immediately.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      byte_q       <= '0;
      parity_q     <= 1'b0;
      bitcnt_q     <= '0;
      cnt_q        <= '0;
      clk_drive_q  <= 1'b0;
      data_drive_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      parity_q     <= parity_d;
      bitcnt_q     <= bitcnt_d;
      cnt_q        <= cnt_d;
      clk_drive_q  <= clk_drive_d;
      data_drive_q <= data_drive_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Pulses are registered so they coincide with the first IDLE cycle, together with tx_ready.
  assign tx_ready           = (state_q == StIdle);
  assign busy               = (state_q != StIdle);
  assign tx_done            = done_q;
  assign tx_error           = error_q;
  assign kbd_clk_drive_low  = clk_drive_q;
  assign kbd_data_drive_low = data_drive_q;

endmodule
